aes_inv: RTL

Multi-cycle inverse AES round stage that undoes the lab's forward round (AddRoundKey → ShiftRows → MixColumns). It accepts a 128-bit state and a 128-bit round key in one valid cycle. It then produces three intermediate results, one per cycle, each tagged by `count`: InvMixColumns, then InvShiftRows, then AddRoundKey. It sits downstream of `aes`; feeding an `aes` result back with the same key returns the original plaintext on `count`=3.

---
 rtl/aes_inv.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/aes_inv.sv
// aes_inv: multi-cycle inverse AES round (InvMixColumns, InvShiftRows, AddRoundKey).
// Optional macro AES_INV_CLEAR_EN clears matrix3 when the sequence returns to idle.
module aes_inv (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid,
   input  logic [127:0] matrix1,
   input  logic [127:0] matrix2,
   output logic [1:0]   count,
   output logic [127:0] matrix3
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IMC  = 2'd1,
      ISR  = 2'd2,
      ARK  = 2'd3
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic [127:0] key;
   logic [127:0] key_nxt;
   logic [127:0] m3_nxt;
   logic [1:0]   cnt_nxt;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // b_r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3)
   function automatic logic [7:0] imc_byte(
      input logic [7:0] a0,
      input logic [7:0] a1,
      input logic [7:0] a2,
      input logic [7:0] a3
   );
      logic [7:0] p2, p4, p8, q2, q4, q8, r2, r4, r8, s8;
      p2 = xt(a0);
      p4 = xt(p2);
      p8 = xt(p4);
      q2 = xt(a1);
      q4 = xt(q2);
      q8 = xt(q4);
      r2 = xt(a2);
      r4 = xt(r2);
      r8 = xt(r4);
      s8 = xt(xt(xt(a3)));
      return (p8 ^ p4 ^ p2) ^ (q8 ^ q2 ^ a1)
           ^ (r8 ^ r4 ^ a2) ^ (s8 ^ a3);
   endfunction

   function automatic logic [31:0] imc_col(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      a0 = a[31:24];
      a1 = a[23:16];
      a2 = a[15:8];
      a3 = a[7:0];
      return {imc_byte(a0, a1, a2, a3),
              imc_byte(a1, a2, a3, a0),
              imc_byte(a2, a3, a0, a1),
              imc_byte(a3, a0, a1, a2)};
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         o[127-32*c -: 32] = imc_col(s[127-32*c -: 32]);
      end
      return o;
   endfunction

   // row r rotated right by r: out[r][c] = in[r][(c-r) mod 4]
   function automatic logic [127:0] inv_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r)&3)+r) -: 8];
         end
      end
      return o;
   endfunction

   // Next state, stage result and key capture; inputs are only looked at in IDLE.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = count;
      m3_nxt    = matrix3;
      key_nxt   = key;
      unique case (state)
         IDLE: begin
            if (valid) begin
               state_nxt = IMC;
               key_nxt   = matrix2;
               m3_nxt    = inv_mix(matrix1);
               cnt_nxt   = 2'd1;
            end
         end
         IMC: begin
            state_nxt = ISR;
            m3_nxt    = inv_shift(matrix3);
            cnt_nxt   = 2'd2;
         end
         ISR: begin
            state_nxt = ARK;
            m3_nxt    = matrix3 ^ key;
            cnt_nxt   = 2'd3;
         end
         ARK: begin
            state_nxt = IDLE;
            cnt_nxt   = 2'd0;
`ifdef AES_INV_CLEAR_EN
            m3_nxt    = '0;
`endif
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 2'd0;
         end
      endcase
   end

   // State, key and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= 2'd0;
         matrix3 <= '0;
         key     <= '0;
      end else begin
         state   <= state_nxt;
         count   <= cnt_nxt;
         matrix3 <= m3_nxt;
         key     <= key_nxt;
      end
   end

endmodule
